mux_data_source_pipe: RTL and testbench

Parametrised, registered successor to the write-back data-source multiplexer. Selects one of `N_SRC` datapath sources (ALU out, shifter, HI/LO, sign-extend, etc.) per transaction and delivers it to the register-file write port through a 2-entry skid buffer with valid/ready handshake. Illegal select codes are dropped and reported instead of producing an undefined write-back value. Sits between the datapath source registers and the register-file write stage.

---
 rtl/mux_data_source_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_mux_data_source_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_data_source_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mux_data_source_pipe
//  Purpose  : Write-back data-source selector with a registered 2-entry skid
//             buffer and a valid/ready handshake on both sides. Select codes
//             at or above N_SRC are accepted and dropped, and are reported
//             through sticky error outputs and a saturating drop counter.
//  Revision : 1.0  initial release
// ============================================================================
module mux_data_source_pipe #(
    parameter int DATA_W = 32,
    parameter int N_SRC  = 10,
    parameter int SEL_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_illegal,
    output logic [SEL_W-1:0]        err_sel,
    output logic [7:0]              drop_cnt,
    input  logic                    err_clr
);

    // Occupancy of the output register (OR) and skid register (SR).
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam logic [7:0] c_DROP_MAX = 8'hFF;

    state_t              r_state;
    state_t              w_next_state;

    logic [DATA_W-1:0]   r_or_data;
    logic [SEL_W-1:0]    r_or_sel;
    logic [DATA_W-1:0]   r_sr_data;
    logic [SEL_W-1:0]    r_sr_sel;
    logic                r_out_valid;
    logic                r_in_ready;

    logic                r_err_illegal;
    logic [SEL_W-1:0]    r_err_sel;
    logic [7:0]          r_drop_cnt;

    logic [DATA_W-1:0]   w_src [N_SRC];
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_sel_legal;
    logic                w_accept;
    logic                w_acc_legal;
    logic                w_acc_illegal;
    logic                w_consume;

    logic                w_load_or_in;
    logic                w_load_or_sr;
    logic                w_load_sr;

    logic                w_err_base_flag;
    logic [SEL_W-1:0]    w_err_base_sel;
    logic [7:0]          w_err_base_cnt;
    logic                w_err_illegal_nxt;
    logic [SEL_W-1:0]    w_err_sel_nxt;
    logic [7:0]          w_drop_cnt_nxt;

    // Split the flattened source bus into one word per source.
    generate
        for (genvar k = 0; k < N_SRC; k++) begin : g_src_unpack
            assign w_src[k] = src_data[k*DATA_W +: DATA_W];
        end
    endgenerate

    // Source multiplexer; out-of-range codes yield zero and are never stored.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                w_sel_data = w_src[k];
            end
        end
    end

    assign w_sel_legal   = (32'(sel) < N_SRC);
    assign w_accept      = in_valid && r_in_ready;
    assign w_acc_legal   = w_accept && w_sel_legal;
    assign w_acc_illegal = w_accept && !w_sel_legal;
    assign w_consume     = r_out_valid && out_ready;

    // Occupancy transitions and the load strobes for OR and SR.
    always_comb begin
        w_next_state = r_state;
        w_load_or_in = 1'b0;
        w_load_or_sr = 1'b0;
        w_load_sr    = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_acc_legal) begin
                    w_next_state = S_ONE;
                    w_load_or_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_acc_legal && w_consume) begin
                    w_load_or_in = 1'b1;
                end else if (w_acc_legal) begin
                    w_next_state = S_TWO;
                    w_load_sr    = 1'b1;
                end else if (w_consume) begin
                    w_next_state = S_EMPTY;
                end
            end
            S_TWO: begin
                // in_ready is low here, so only a consume can move the state.
                if (w_consume) begin
                    w_next_state = S_ONE;
                    w_load_or_sr = 1'b1;
                end
            end
            default: begin
                w_next_state = S_EMPTY;
            end
        endcase
    end

    // State register plus registered handshake flags derived from next state,
    // so in_ready has no combinational path from out_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_out_valid <= (w_next_state != S_EMPTY);
            r_in_ready  <= (w_next_state != S_TWO);
        end
    end

    // Output register: fresh input or the skid entry; holds otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_or_data <= '0;
            r_or_sel  <= '0;
        end else if (w_load_or_in) begin
            r_or_data <= w_sel_data;
            r_or_sel  <= sel;
        end else if (w_load_or_sr) begin
            r_or_data <= r_sr_data;
            r_or_sel  <= r_sr_sel;
        end
    end

    // Skid register captures the one transaction accepted while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr_data <= '0;
            r_sr_sel  <= '0;
        end else if (w_load_sr) begin
            r_sr_data <= w_sel_data;
            r_sr_sel  <= sel;
        end
    end

    // Error bookkeeping: a clear applies to the old state first, then any
    // illegal accept in the same cycle is recorded on top of the cleared state.
    always_comb begin
        w_err_base_flag   = err_clr ? 1'b0 : r_err_illegal;
        w_err_base_sel    = err_clr ? '0   : r_err_sel;
        w_err_base_cnt    = err_clr ? 8'd0 : r_drop_cnt;
        w_err_illegal_nxt = w_err_base_flag;
        w_err_sel_nxt     = w_err_base_sel;
        w_drop_cnt_nxt    = w_err_base_cnt;
        if (w_acc_illegal) begin
            w_err_illegal_nxt = 1'b1;
            if (!w_err_base_flag) begin
                w_err_sel_nxt = sel;
            end
            if (w_err_base_cnt != c_DROP_MAX) begin
                w_drop_cnt_nxt = w_err_base_cnt + 8'd1;
            end
        end
    end

    // Error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_illegal <= 1'b0;
            r_err_sel     <= '0;
            r_drop_cnt    <= 8'd0;
        end else begin
            r_err_illegal <= w_err_illegal_nxt;
            r_err_sel     <= w_err_sel_nxt;
            r_drop_cnt    <= w_drop_cnt_nxt;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_or_data;
    assign out_sel     = r_or_sel;
    assign err_illegal = r_err_illegal;
    assign err_sel     = r_err_sel;
    assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux_data_source_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_data_source_pipe
//  Purpose  : Scoreboard bench for mux_data_source_pipe: directed scenarios
//             followed by randomized traffic against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_data_source_pipe;

    localparam int DATA_W = 32;
    localparam int N_SRC  = 10;
    localparam int SEL_W  = 4;

    logic                    clk;
    logic                    reset;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready;
    logic                    err_illegal;
    logic [SEL_W-1:0]        err_sel;
    logic [7:0]              drop_cnt;
    logic                    err_clr;

    logic [DATA_W-1:0]       srcs [N_SRC];

    int checks = 0;
    int errors = 0;

    // Expected deliveries in order: {data, sel}.
    logic [DATA_W+SEL_W-1:0] exp_q [$];

    // Error-reporting model.
    logic                    m_err = 1'b0;
    logic [SEL_W-1:0]        m_sel = '0;
    int                      m_cnt = 0;

    // Values sampled on the falling edge for the following rising edge.
    logic                    smp_acc  = 1'b0;
    logic                    smp_clr  = 1'b0;
    logic [SEL_W-1:0]        smp_sel  = '0;
    logic [DATA_W-1:0]       smp_data = '0;

    logic                    stall_prev = 1'b0;
    logic [DATA_W-1:0]       prev_data  = '0;
    logic [SEL_W-1:0]        prev_sel   = '0;

    mux_data_source_pipe #(
        .DATA_W (DATA_W),
        .N_SRC  (N_SRC),
        .SEL_W  (SEL_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .src_data    (src_data),
        .sel         (sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_sel     (out_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_illegal (err_illegal),
        .err_sel     (err_sel),
        .drop_cnt    (drop_cnt),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        src_data = '0;
        for (int k = 0; k < N_SRC; k++) begin
            src_data[k*DATA_W +: DATA_W] = srcs[k];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Advance one cycle; inputs are then changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold an offer until the handshake completes (bounded).
    task automatic offer(input logic [SEL_W-1:0] s);
        logic acc;
        in_valid = 1'b1;
        sel      = s;
        acc      = 1'b0;
        for (int n = 0; n < 64 && !acc; n++) begin
            acc = in_ready;
            step();
        end
        chk("offer_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
            step();
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Sample the offered transaction just before the rising edge.
    always @(negedge clk) begin
        smp_acc  = reset && in_valid && in_ready;
        smp_clr  = reset && err_clr;
        smp_sel  = sel;
        smp_data = (32'(sel) < N_SRC) ? srcs[int'(sel)] : '0;
    end

    // Reference model: legal accepts are queued, illegal ones update the
    // error record; reset discards everything.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            m_err = 1'b0;
            m_sel = '0;
            m_cnt = 0;
        end else begin
            if (smp_clr) begin
                m_err = 1'b0;
                m_sel = '0;
                m_cnt = 0;
            end
            if (smp_acc) begin
                if (32'(smp_sel) < N_SRC) begin
                    exp_q.push_back({smp_data, smp_sel});
                end else begin
                    if (!m_err) m_sel = smp_sel;
                    m_err = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
    end

    // Monitor: compares flags against model occupancy and pops on consume.
    always @(negedge clk) begin
        logic [DATA_W+SEL_W-1:0] head;
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
        chk("err_illegal", 32'(err_illegal), 32'(m_err));
        chk("err_sel", 32'(err_sel), 32'(m_sel));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
        if (stall_prev && out_valid) begin
            chk("stall_data", out_data, prev_data);
            chk("stall_sel", 32'(out_sel), 32'(prev_sel));
        end
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=0x%0h/%0d required=none at %0t",
                         out_data, out_sel, $time);
            end else begin
                head = exp_q.pop_front();
                chk("sb_data", out_data, head[DATA_W+SEL_W-1:SEL_W]);
                chk("sb_sel", 32'(out_sel), 32'(head[SEL_W-1:0]));
            end
        end
        stall_prev = reset && out_valid && !out_ready;
        prev_data  = out_data;
        prev_sel   = out_sel;
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        for (int k = 0; k < N_SRC; k++) srcs[k] = $urandom;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Reset state
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_err_illegal", 32'(err_illegal), 32'd0);
        chk("rst_err_sel", 32'(err_sel), 32'd0);

        // Single transfer
        srcs[3]   = 32'hDEADBEEF;
        out_ready = 1'b1;
        offer(4'd3);
        in_valid = 1'b0;
        srcs[3]  = 32'h0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", out_data, 32'hDEADBEEF);
        chk("single_sel", 32'(out_sel), 32'd3);
        step();
        chk("single_gone", 32'(out_valid), 32'd0);

        // Streaming
        for (int k = 0; k < N_SRC; k++) srcs[k] = 32'h1000 + k;
        for (int k = 0; k < N_SRC; k++) begin
            in_valid = 1'b1;
            sel      = SEL_W'(k);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            step();
            chk("stream_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        wait_drain();

        // Backpressure
        out_ready = 1'b0;
        srcs[1] = 32'hB001;
        srcs[2] = 32'hB002;
        srcs[3] = 32'hB003;
        in_valid = 1'b1;
        sel = 4'd1;
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        step();
        sel = 4'd2;
        chk("bp_rdy2", 32'(in_ready), 32'd1);
        step();
        sel = 4'd3;
        chk("bp_rdy3_low", 32'(in_ready), 32'd0);
        repeat (3) step();
        chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        chk("bp_hold_data", out_data, 32'hB001);
        out_ready = 1'b1;
        offer(4'd3);
        in_valid = 1'b0;
        wait_drain();

        // Illegal selects
        srcs[4] = 32'h4444_0004;
        offer(4'd12);
        offer(4'd15);
        offer(4'd4);
        in_valid = 1'b0;
        step();
        step();
        chk("ill_flag", 32'(err_illegal), 32'd1);
        chk("ill_sel", 32'(err_sel), 32'd12);
        chk("ill_cnt", 32'(drop_cnt), 32'd2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_flag", 32'(err_illegal), 32'd0);
        chk("clr_sel", 32'(err_sel), 32'd0);
        chk("clr_cnt", 32'(drop_cnt), 32'd0);

        // Clear together with a new illegal accept
        offer(4'd11);
        sel     = 4'd13;
        err_clr = 1'b1;
        step();
        err_clr  = 1'b0;
        in_valid = 1'b0;
        chk("clrill_flag", 32'(err_illegal), 32'd1);
        chk("clrill_sel", 32'(err_sel), 32'd13);
        chk("clrill_cnt", 32'(drop_cnt), 32'd1);

        // Drop counter saturation
        err_clr = 1'b1;
        step();
        err_clr  = 1'b0;
        in_valid = 1'b1;
        sel      = 4'd14;
        repeat (260) step();
        in_valid = 1'b0;
        step();
        chk("sat_cnt", 32'(drop_cnt), 32'd255);
        chk("sat_sel", 32'(err_sel), 32'd14);

        // Reset mid-stream while both registers are full
        out_ready = 1'b0;
        offer(4'd5);
        offer(4'd6);
        in_valid = 1'b0;
        chk("mid_two", 32'(in_ready), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("mid_async_valid", 32'(out_valid), 32'd0);
        chk("mid_async_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        chk("mid_no_stale", 32'(out_valid), 32'd0);
        srcs[7] = 32'h7777_0007;
        offer(4'd7);
        in_valid = 1'b0;
        wait_drain();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(3) != 0);
            sel       = SEL_W'($urandom_range(15));
            out_ready = ($urandom_range(2) != 0);
            err_clr   = ($urandom_range(31) == 0);
            for (int k = 0; k < N_SRC; k++) srcs[k] = $urandom;
            step();
        end
        in_valid  = 1'b0;
        err_clr   = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
